saturn_bus_master: RTL and testbench
====================================

SATURN_BUS_MASTER -- requirements
Module: saturn_bus_master

Interface
REQ-001 The block SHALL have one clock, i_clk, and an asynchronous active-low reset, i_reset_n; i_reset_n low SHALL clear all state immediately, independent of i_clk.
REQ-002 Ports, listed as name, direction, width, meaning:
- i_clk in 1: rising-edge clock.
- i_reset_n in 1: async active-low reset.
- i_clk_en in 1: cycle qualifier; all state advances only when 1.
- i_req_valid in 1: core request valid.
- o_req_ready out 1: master idle, request accepted.
- i_req_is_dp in 1: 0 = PC pointer, 1 = DP pointer.
- i_req_write in 1: 0 = read, 1 = write.
- i_req_addr in 20: start nibble address.
- i_req_len in 4: nibble count, 0 = 16.
- i_req_wr_data in 64: write nibble k = bits [4k+3:4k].
- o_rd_data out 4: read nibble.
- o_rd_valid out 1: one-cycle pulse per read nibble.
- o_rd_last out 1: with o_rd_valid, marks the final nibble.
- o_bus_clk_en out 1: bus strobe.
- o_bus_is_data out 1: 0 = command nibble, 1 = data/address nibble.
- o_bus_nibble_out out 4: nibble driven to slaves.
- i_bus_nibble_in in 4: nibble returned by the selected slave.
REQ-003 Command codes SHALL come from the shared bus command definitions: PC_READ 0x0, DP_READ 0x1, PC_WRITE 0x2, DP_WRITE 0x3, LOAD_PC 0x4, LOAD_DP 0x5.

Function
REQ-004 States SHALL be IDLE, LOAD_CMD, ADDR, XFER_CMD, DATA, and DRAIN; o_req_ready=1 only in IDLE.
REQ-005 A request SHALL be accepted when i_clk_en, i_req_valid, and o_req_ready are all 1; request fields SHALL be latched on acceptance.
REQ-006 Per pointer, the block SHALL keep a 20-bit shadow address and a valid bit, plus a 4-bit last_cmd register with a valid bit.
REQ-007 On acceptance, if the selected shadow is invalid or differs from i_req_addr, the next state SHALL be LOAD_CMD; otherwise it SHALL be XFER_CMD if last_cmd differs from the needed transfer command, else DATA.
REQ-008 Every state except IDLE and DRAIN SHALL emit exactly one bus strobe per i_clk_en cycle: o_bus_clk_en=1 for that one i_clk cycle, with o_bus_is_data and o_bus_nibble_out valid in the same cycle.
REQ-009 LOAD_CMD SHALL emit is_data=0 with LOAD_PC or LOAD_DP, then go to ADDR.
REQ-010 ADDR SHALL emit 5 strobes with is_data=1, carrying address nibbles least significant first.
- After the 5th: a read SHALL go straight to DATA, and last_cmd SHALL become PC_READ/DP_READ, because the slave auto-switches.
- After the 5th: a write SHALL go to XFER_CMD.
REQ-011 XFER_CMD SHALL emit is_data=0 with the transfer command, set last_cmd to it, then go to DATA.
REQ-012 DATA SHALL emit len strobes with is_data=1; for writes, strobe k SHALL carry write nibble k; for reads, the nibble driven is don't-care and SHALL be 0.
REQ-013 Read capture: i_bus_nibble_in SHALL be sampled on the i_clk_en cycle after each read strobe and presented on o_rd_data with a one-cycle o_rd_valid; o_rd_last SHALL accompany the nibble for strobe len.
REQ-014 After the final read strobe the block SHALL pass through DRAIN for one i_clk_en cycle, emitting no strobe, to capture the last nibble; writes SHALL return to IDLE directly.
REQ-015 On completion the selected shadow SHALL equal (addr+len) mod 2^20 and be valid; the other shadow SHALL be unchanged.
- Wrap: 0xFFFFF+1 = 0x00000.
REQ-016 With i_clk_en=0: no state change, o_bus_clk_en=0, o_rd_valid=0, and no acceptance.
REQ-017 A request arriving while not IDLE SHALL be held off by o_req_ready=0; no queueing.

Reset
REQ-018 On reset:
- state = IDLE; o_req_ready = 1.
- o_bus_clk_en, o_bus_is_data, o_bus_nibble_out, o_rd_data, o_rd_valid, o_rd_last = 0.
- both shadow valid bits and the last_cmd valid bit = 0.
REQ-019 Reset asserted mid-transfer SHALL abort immediately; the next request SHALL always take the LOAD path.

Verification
REQ-020 After reset, read PC 0x12345 len 2 -> bus 4(cmd), 5,4,3,2,1(data), 2 data strobes; 2 o_rd_valid pulses echoing the slave nibbles, last on 2nd; PC shadow = 0x12347.
REQ-021 Then read PC 0x12347 len 1 -> exactly one data strobe, no command; o_rd_valid and o_rd_last together.
REQ-022 Write DP 0xFFFFF len 2, data 0xA,0xB -> 5(cmd), F×5, 3(cmd), A, B; DP shadow = 0x00001.
REQ-023 Then read PC 0x12348 len 1 -> 0(cmd) then one data strobe (shadow matches, last_cmd was DP_WRITE).
REQ-024 Toggle i_clk_en 0/1 every cycle during REQ-020 -> identical strobe sequence, one strobe per enabled cycle, none when disabled.
REQ-025 Pull i_reset_n low after the 3rd address nibble -> outputs zero that cycle, o_req_ready=1; a repeat of the same request reissues LOAD_PC.

Source files
------------

// File: rtl/saturn_bus_master.sv
// saturn_bus_master
//
// Nibble-serial bus master for a Saturn-style core. A request names a pointer (PC or DP), a
// direction, a start nibble address and a nibble count. The master keeps a shadow copy of each
// slave-side pointer and of the last transfer command it issued, so it only sends LOAD_x plus
// five address nibbles when the slave pointer is wrong, and only sends a transfer command when
// the slave is not already in the required mode.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset_n        asynchronous active-low reset
//   i_clk_en         cycle qualifier; all state advances only when 1
//   i_req_valid      core request valid
//   o_req_ready      master idle; request accepted when valid, ready and i_clk_en
//   i_req_is_dp      0 = PC pointer, 1 = DP pointer
//   i_req_write      0 = read, 1 = write
//   i_req_addr       start nibble address
//   i_req_len        nibble count, 0 means 16
//   i_req_wr_data    write nibble k in bits [4k+3:4k]
//   o_rd_data        read nibble
//   o_rd_valid       one-cycle pulse per read nibble
//   o_rd_last        with o_rd_valid, marks the final nibble
//   o_bus_clk_en     bus strobe
//   o_bus_is_data    0 = command nibble, 1 = data/address nibble
//   o_bus_nibble_out nibble driven to the slaves
//   i_bus_nibble_in  nibble returned by the selected slave

module saturn_bus_master (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_clk_en,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_is_dp,
    input  logic        i_req_write,
    input  logic [19:0] i_req_addr,
    input  logic [3:0]  i_req_len,
    input  logic [63:0] i_req_wr_data,
    output logic [3:0]  o_rd_data,
    output logic        o_rd_valid,
    output logic        o_rd_last,
    output logic        o_bus_clk_en,
    output logic        o_bus_is_data,
    output logic [3:0]  o_bus_nibble_out,
    input  logic [3:0]  i_bus_nibble_in
);

    // Shared bus command codes. Transfer commands are {2'b00, write, is_dp} and load
    // commands are {3'b010, is_dp}, which the encoders below rely on.
    localparam logic [3:0] CMD_PC_READ  = 4'h0;
    localparam logic [3:0] CMD_DP_READ  = 4'h1;
    localparam logic [3:0] CMD_PC_WRITE = 4'h2;
    localparam logic [3:0] CMD_DP_WRITE = 4'h3;
    localparam logic [3:0] CMD_LOAD_PC  = 4'h4;
    localparam logic [3:0] CMD_LOAD_DP  = 4'h5;

    typedef enum logic [2:0] {
        StIdle,
        StLoadCmd,
        StAddr,
        StXferCmd,
        StData,
        StDrain
    } state_e;

    state_e      state_q, state_d;
    logic        is_dp_q, is_dp_d;
    logic        write_q, write_d;
    logic [19:0] addr_q, addr_d;
    logic [3:0]  len_q, len_d;
    logic [63:0] wr_data_q, wr_data_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [19:0] pc_shadow_q, pc_shadow_d;
    logic        pc_valid_q, pc_valid_d;
    logic [19:0] dp_shadow_q, dp_shadow_d;
    logic        dp_valid_q, dp_valid_d;
    logic [3:0]  last_cmd_q, last_cmd_d;
    logic        last_cmd_valid_q, last_cmd_valid_d;
    logic        rd_pend_q, rd_pend_d;
    logic        rd_last_q, rd_last_d;

    logic        strobe;
    logic        bus_is_data;
    logic [3:0]  bus_nib;
    logic        req_hit;
    logic [3:0]  req_xfer_cmd;
    logic [3:0]  load_cmd;
    logic [3:0]  xfer_cmd;
    logic [4:0]  len_ext;
    logic [19:0] end_addr;
    logic        data_last;

    assign req_hit      = i_req_is_dp ? (dp_valid_q && dp_shadow_q == i_req_addr)
                                      : (pc_valid_q && pc_shadow_q == i_req_addr);
    assign req_xfer_cmd = i_req_is_dp ? (i_req_write ? CMD_DP_WRITE : CMD_DP_READ)
                                      : (i_req_write ? CMD_PC_WRITE : CMD_PC_READ);
    assign load_cmd     = is_dp_q ? CMD_LOAD_DP : CMD_LOAD_PC;
    assign xfer_cmd     = {2'b00, write_q, is_dp_q};
    assign len_ext      = (len_q == 4'd0) ? 5'd16 : {1'b0, len_q};
    // 20-bit add wraps naturally past 0xFFFFF.
    assign end_addr     = addr_q + 20'(len_ext);
    // len 0 means 16, so the last data index is len-1 in 4-bit arithmetic.
    assign data_last    = (cnt_q == len_q - 4'd1);

    always_comb begin
        state_d          = state_q;
        is_dp_d          = is_dp_q;
        write_d          = write_q;
        addr_d           = addr_q;
        len_d            = len_q;
        wr_data_d        = wr_data_q;
        cnt_d            = cnt_q;
        pc_shadow_d      = pc_shadow_q;
        pc_valid_d       = pc_valid_q;
        dp_shadow_d      = dp_shadow_q;
        dp_valid_d       = dp_valid_q;
        last_cmd_d       = last_cmd_q;
        last_cmd_valid_d = last_cmd_valid_q;
        // A pending read capture is consumed on the very next enabled cycle.
        rd_pend_d        = 1'b0;
        rd_last_d        = 1'b0;
        strobe           = 1'b0;
        bus_is_data      = 1'b0;
        bus_nib          = 4'h0;

        unique case (state_q)
            StIdle: begin
                if (i_req_valid) begin
                    is_dp_d   = i_req_is_dp;
                    write_d   = i_req_write;
                    addr_d    = i_req_addr;
                    len_d     = i_req_len;
                    wr_data_d = i_req_wr_data;
                    cnt_d     = 4'd0;
                    if (!req_hit) begin
                        state_d = StLoadCmd;
                    end else if (last_cmd_valid_q && last_cmd_q == req_xfer_cmd) begin
                        state_d = StData;
                    end else begin
                        state_d = StXferCmd;
                    end
                end
            end
            StLoadCmd: begin
                strobe  = 1'b1;
                bus_nib = load_cmd;
                cnt_d   = 4'd0;
                state_d = StAddr;
            end
            StAddr: begin
                strobe      = 1'b1;
                bus_is_data = 1'b1;
                bus_nib     = addr_q[{cnt_q[2:0], 2'b00} +: 4];
                cnt_d       = cnt_q + 4'd1;
                if (cnt_q == 4'd4) begin
                    cnt_d = 4'd0;
                    if (write_q) begin
                        state_d = StXferCmd;
                    end else begin
                        // The slave drops into read mode by itself after a pointer load.
                        last_cmd_d       = xfer_cmd;
                        last_cmd_valid_d = 1'b1;
                        state_d          = StData;
                    end
                end
            end
            StXferCmd: begin
                strobe           = 1'b1;
                bus_nib          = xfer_cmd;
                last_cmd_d       = xfer_cmd;
                last_cmd_valid_d = 1'b1;
                cnt_d            = 4'd0;
                state_d          = StData;
            end
            StData: begin
                strobe      = 1'b1;
                bus_is_data = 1'b1;
                bus_nib     = write_q ? wr_data_q[{cnt_q, 2'b00} +: 4] : 4'h0;
                cnt_d       = cnt_q + 4'd1;
                if (!write_q) begin
                    rd_pend_d = 1'b1;
                    rd_last_d = data_last;
                end
                if (data_last) begin
                    if (write_q) begin
                        state_d = StIdle;
                        if (is_dp_q) begin
                            dp_shadow_d = end_addr;
                            dp_valid_d  = 1'b1;
                        end else begin
                            pc_shadow_d = end_addr;
                            pc_valid_d  = 1'b1;
                        end
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                // No strobe: this cycle only exists to capture the final read nibble.
                state_d = StIdle;
                if (is_dp_q) begin
                    dp_shadow_d = end_addr;
                    dp_valid_d  = 1'b1;
                end else begin
                    pc_shadow_d = end_addr;
                    pc_valid_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q          <= StIdle;
            is_dp_q          <= 1'b0;
            write_q          <= 1'b0;
            addr_q           <= 20'h0;
            len_q            <= 4'h0;
            wr_data_q        <= 64'h0;
            cnt_q            <= 4'h0;
            pc_shadow_q      <= 20'h0;
            pc_valid_q       <= 1'b0;
            dp_shadow_q      <= 20'h0;
            dp_valid_q       <= 1'b0;
            last_cmd_q       <= 4'h0;
            last_cmd_valid_q <= 1'b0;
            rd_pend_q        <= 1'b0;
            rd_last_q        <= 1'b0;
        end else if (i_clk_en) begin
            state_q          <= state_d;
            is_dp_q          <= is_dp_d;
            write_q          <= write_d;
            addr_q           <= addr_d;
            len_q            <= len_d;
            wr_data_q        <= wr_data_d;
            cnt_q            <= cnt_d;
            pc_shadow_q      <= pc_shadow_d;
            pc_valid_q       <= pc_valid_d;
            dp_shadow_q      <= dp_shadow_d;
            dp_valid_q       <= dp_valid_d;
            last_cmd_q       <= last_cmd_d;
            last_cmd_valid_q <= last_cmd_valid_d;
            rd_pend_q        <= rd_pend_d;
            rd_last_q        <= rd_last_d;
        end
    end

    assign o_req_ready      = (state_q == StIdle);
    assign o_bus_clk_en     = i_clk_en & strobe;
    assign o_bus_is_data    = o_bus_clk_en & bus_is_data;
    assign o_bus_nibble_out = o_bus_clk_en ? bus_nib : 4'h0;
    // The slave answers during the enabled cycle after a read strobe; pass it straight through.
    assign o_rd_valid       = i_clk_en & rd_pend_q;
    assign o_rd_last        = o_rd_valid & rd_last_q;
    assign o_rd_data        = o_rd_valid ? i_bus_nibble_in : 4'h0;

endmodule

// File: tb/tb_saturn_bus_master.sv
// Directed bench for saturn_bus_master: a table of requests with hand-computed path flags and
// final shadow values, followed by hand-written clock-enable, reset and hold-off sequences.

module tb_saturn_bus_master;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_clk_en = 1'b0;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_is_dp = 1'b0;
    logic        i_req_write = 1'b0;
    logic [19:0] i_req_addr = 20'h0;
    logic [3:0]  i_req_len = 4'h0;
    logic [63:0] i_req_wr_data = 64'h0;
    logic [3:0]  o_rd_data;
    logic        o_rd_valid;
    logic        o_rd_last;
    logic        o_bus_clk_en;
    logic        o_bus_is_data;
    logic [3:0]  o_bus_nibble_out;
    logic [3:0]  i_bus_nibble_in = 4'h0;

    saturn_bus_master dut (
        .i_clk            (i_clk),
        .i_reset_n        (i_reset_n),
        .i_clk_en         (i_clk_en),
        .i_req_valid      (i_req_valid),
        .o_req_ready      (o_req_ready),
        .i_req_is_dp      (i_req_is_dp),
        .i_req_write      (i_req_write),
        .i_req_addr       (i_req_addr),
        .i_req_len        (i_req_len),
        .i_req_wr_data    (i_req_wr_data),
        .o_rd_data        (o_rd_data),
        .o_rd_valid       (o_rd_valid),
        .o_rd_last        (o_rd_last),
        .o_bus_clk_en     (o_bus_clk_en),
        .o_bus_is_data    (o_bus_is_data),
        .o_bus_nibble_out (o_bus_nibble_out),
        .i_bus_nibble_in  (i_bus_nibble_in)
    );

    typedef struct {
        logic        is_dp;
        logic        wr;
        logic [19:0] addr;
        logic [3:0]  len;
        logic [63:0] wdata;
        logic        exp_load;
        logic        exp_xfer;
        logic [19:0] exp_shadow;
    } vec_t;

    int n_vec = 0;
    int n_miss = 0;
    int str_idx = 0;
    int viol = 0;
    int ce_mode = 0;  // 0 = always on, 1 = toggle every cycle, 2 = off
    logic [4:0] strobe_q[$];  // {is_data, nibble}
    logic [4:0] rd_q[$];      // {last, data}
    vec_t tab[9];
    vec_t v_late;

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        #1;
        case (ce_mode)
            0:       i_clk_en = 1'b1;
            1:       i_clk_en = ~i_clk_en;
            default: i_clk_en = 1'b0;
        endcase
    end

    // Slave answer for the strobe with global index i.
    function automatic logic [3:0] slave_nib(input int i);
        return 4'((i * 5 + 3) & 15);
    endfunction

    // Bus monitor and slave model, sampled mid-cycle.
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            if (o_rd_valid) begin
                if (!i_clk_en) viol++;
                rd_q.push_back({o_rd_last, o_rd_data});
            end
            if (o_bus_clk_en) begin
                if (!i_clk_en || o_req_ready) viol++;
                strobe_q.push_back({o_bus_is_data, o_bus_nibble_out});
                str_idx++;
                i_bus_nibble_in = slave_nib(str_idx);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic start_req(input vec_t v);
        bit acc;
        acc = 1'b0;
        @(posedge i_clk);
        #2;
        i_req_is_dp   = v.is_dp;
        i_req_write   = v.wr;
        i_req_addr    = v.addr;
        i_req_len     = v.len;
        i_req_wr_data = v.wdata;
        i_req_valid   = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge i_clk);
            if (o_req_ready && i_clk_en) begin
                acc = 1'b1;
                break;
            end
        end
        if (!acc) chk("accept timeout", 64'd0, 64'd1);
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
    endtask

    task automatic wait_done();
        bit done;
        done = 1'b0;
        for (int t = 0; t < 500; t++) begin
            @(negedge i_clk);
            if (o_req_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("done timeout", 64'd0, 64'd1);
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int base, n, k0;
        logic [4:0] exp_s[$];
        logic [20:0] shadow;
        base = str_idx;
        strobe_q.delete();
        rd_q.delete();
        start_req(v);
        wait_done();
        if (v.exp_load) begin
            exp_s.push_back({1'b0, 3'b010, v.is_dp});
            for (int i = 0; i < 5; i++) exp_s.push_back({1'b1, v.addr[4*i +: 4]});
        end
        if (v.exp_xfer) exp_s.push_back({1'b0, 2'b00, v.wr, v.is_dp});
        n  = (v.len == 4'd0) ? 16 : int'(v.len);
        k0 = exp_s.size();
        for (int k = 0; k < n; k++) exp_s.push_back({1'b1, v.wr ? v.wdata[4*k +: 4] : 4'h0});
        chk($sformatf("%s strobe count", tag), 64'(strobe_q.size()), 64'(exp_s.size()));
        for (int i = 0; i < exp_s.size() && i < strobe_q.size(); i++)
            chk($sformatf("%s strobe%0d", tag, i), 64'(strobe_q[i]), 64'(exp_s[i]));
        if (!v.wr) begin
            chk($sformatf("%s rd count", tag), 64'(rd_q.size()), 64'(n));
            for (int m = 0; m < n && m < rd_q.size(); m++)
                chk($sformatf("%s rd%0d", tag, m), 64'(rd_q[m]),
                    64'({(m == n - 1), slave_nib(base + k0 + m + 1)}));
        end else begin
            chk($sformatf("%s rd count", tag), 64'(rd_q.size()), 64'd0);
        end
        shadow = v.is_dp ? {dut.dp_valid_q, dut.dp_shadow_q} : {dut.pc_valid_q, dut.pc_shadow_q};
        chk($sformatf("%s shadow", tag), 64'(shadow), 64'({1'b1, v.exp_shadow}));
    endtask

    task automatic pulse_reset();
        @(negedge i_clk);
        i_reset_n = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
    endtask

    initial begin
        //          dp wr addr       len  wdata                   load xfer shadow
        tab[0] = '{1'b0, 1'b0, 20'h12345, 4'd2, 64'h0, 1'b1, 1'b0, 20'h12347};
        tab[1] = '{1'b0, 1'b0, 20'h12347, 4'd1, 64'h0, 1'b0, 1'b0, 20'h12348};
        tab[2] = '{1'b1, 1'b1, 20'hFFFFF, 4'd2, 64'hBA, 1'b1, 1'b1, 20'h00001};
        tab[3] = '{1'b0, 1'b0, 20'h12348, 4'd1, 64'h0, 1'b0, 1'b1, 20'h12349};
        tab[4] = '{1'b1, 1'b1, 20'h00001, 4'd0, 64'hFEDCBA9876543210, 1'b0, 1'b1, 20'h00011};
        tab[5] = '{1'b1, 1'b1, 20'h00011, 4'd3, 64'h123, 1'b0, 1'b0, 20'h00014};
        tab[6] = '{1'b1, 1'b0, 20'h00014, 4'd0, 64'h0, 1'b0, 1'b1, 20'h00024};
        tab[7] = '{1'b0, 1'b0, 20'h00000, 4'd1, 64'h0, 1'b1, 1'b0, 20'h00001};
        tab[8] = '{1'b0, 1'b1, 20'hFFFFE, 4'd4, 64'h4321, 1'b1, 1'b1, 20'h00002};
        // PC shadow 0x00002 matches; last command was PC_WRITE so PC_READ must be sent.
        v_late = '{1'b0, 1'b0, 20'h00002, 4'd1, 64'h0, 1'b0, 1'b1, 20'h00003};

        // Reset state.
        #3;
        chk("reset ready", 64'(o_req_ready), 64'd1);
        chk("reset outputs", 64'({o_bus_clk_en, o_bus_is_data, o_bus_nibble_out,
                                  o_rd_data, o_rd_valid, o_rd_last}), 64'd0);
        chk("reset valid bits", 64'({dut.pc_valid_q, dut.dp_valid_q, dut.last_cmd_valid_q}),
            64'd0);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;

        for (int i = 0; i < 9; i++) run_txn(tab[i], $sformatf("vec%0d", i));

        // Requests are not accepted while the clock enable is low.
        ce_mode = 2;
        @(posedge i_clk);
        #2;
        strobe_q.delete();
        i_req_is_dp   = v_late.is_dp;
        i_req_write   = v_late.wr;
        i_req_addr    = v_late.addr;
        i_req_len     = v_late.len;
        i_req_valid   = 1'b1;
        repeat (6) @(negedge i_clk);
        chk("ce off strobes", 64'(strobe_q.size()), 64'd0);
        chk("ce off ready", 64'(o_req_ready), 64'd1);
        ce_mode = 0;
        run_txn(v_late, "late");
        chk("monitor violations", 64'(viol), 64'd0);

        // Same transfer as vec0 with the clock enable toggling every cycle.
        pulse_reset();
        ce_mode = 1;
        run_txn(tab[0], "toggle");
        ce_mode = 0;
        chk("toggle violations", 64'(viol), 64'd0);

        // Reset in the middle of the address phase.
        pulse_reset();
        strobe_q.delete();
        start_req(tab[0]);
        for (int t = 0; t < 50 && strobe_q.size() < 4; t++) @(negedge i_clk);
        chk("pre-abort strobes", 64'(strobe_q.size()), 64'd4);
        if (strobe_q.size() >= 4) chk("3rd addr nibble", 64'(strobe_q[3]), 64'h13);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("abort outputs", 64'({o_bus_clk_en, o_bus_is_data, o_bus_nibble_out,
                                  o_rd_data, o_rd_valid, o_rd_last}), 64'd0);
        chk("abort ready", 64'(o_req_ready), 64'd1);
        repeat (2) @(posedge i_clk);
        #1;
        i_reset_n = 1'b1;
        run_txn(tab[0], "reissue");
        chk("final violations", 64'(viol), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
